// File: rtl/pck_control.sv
`default_nettype none
// ============================================================================
// Module      : pck_control
// Description : Shared control types for the ALU datapath: the original 4-bit
//               op select, the extended 5-bit op select and the flag bundle.
// Revision    : 1.0 - extended op set and flag struct for alu_pipe
// ============================================================================
package pck_control;

    // Original op select; existing users keep decoding this unchanged.
    typedef enum logic [3:0] {
        alu_nop  = 4'd0,
        alu_add  = 4'd1,
        alu_sub  = 4'd2,
        alu_and  = 4'd3,
        alu_or   = 4'd4,
        alu_xor  = 4'd5,
        alu_slt  = 4'd6,
        alu_sltu = 4'd7,
        alu_sll  = 4'd8,
        alu_srl  = 4'd9,
        alu_sra  = 4'd10,
        alu_cpa  = 4'd11,
        alu_cpb  = 4'd12
    } sel_alu_op_e;

    // Extended op select; 0..12 mirror sel_alu_op_e, 20..31 are illegal.
    typedef enum logic [4:0] {
        alux_nop  = 5'd0,
        alux_add  = 5'd1,
        alux_sub  = 5'd2,
        alux_and  = 5'd3,
        alux_or   = 5'd4,
        alux_xor  = 5'd5,
        alux_slt  = 5'd6,
        alux_sltu = 5'd7,
        alux_sll  = 5'd8,
        alux_srl  = 5'd9,
        alux_sra  = 5'd10,
        alux_cpa  = 5'd11,
        alux_cpb  = 5'd12,
        alux_min  = 5'd13,
        alux_max  = 5'd14,
        alux_minu = 5'd15,
        alux_maxu = 5'd16,
        alux_rol  = 5'd17,
        alux_ror  = 5'd18,
        alux_mul  = 5'd19
    } sel_alu_op_ext_e;

    // Status flags travelling with each result.
    typedef struct packed {
        logic illegal;
        logic overflow;
        logic carry;
        logic zero;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative shift-add multiplier returning the low WIDTH bits of
//               a*b. Consumes MUL_BITS_PER_CYCLE bits of b per cycle, LSB
//               first; the first digit is folded into the start cycle so the
//               product is ready MUL_CYCLES-1 cycles after start.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter
    import pck_control::*;
#(
    parameter int WIDTH              = 32,
    parameter int MUL_BITS_PER_CYCLE = 4
) (
    input  logic             i_clk,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    input  logic             i_take,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int c_MUL_CYCLES = WIDTH / MUL_BITS_PER_CYCLE;
    localparam int c_CNT_W      = $clog2(c_MUL_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_MUL_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    logic [WIDTH-1:0]              w_mcand;
    logic [WIDTH-1:0]              w_mplier;
    logic [WIDTH-1:0]              w_acc_in;
    logic [MUL_BITS_PER_CYCLE-1:0] w_digit;
    logic [WIDTH-1:0]              w_acc_next;

    // One shift-add step; on start it works directly on the incoming operands.
    always_comb begin
        w_mcand    = i_start ? i_a : r_mcand;
        w_mplier   = i_start ? i_b : r_mplier;
        w_acc_in   = i_start ? '0  : r_acc;
        w_digit    = w_mplier[MUL_BITS_PER_CYCLE-1:0];
        w_acc_next = w_acc_in + (w_mcand * WIDTH'(w_digit));
    end

    // Iteration state: counter saturates at the last digit and the product
    // is held until the consumer takes it.
    always_ff @(posedge i_clk) begin
        if (i_abort) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= c_CNT_ONE;
            r_acc    <= w_acc_next;
            r_mcand  <= w_mcand << MUL_BITS_PER_CYCLE;
            r_mplier <= w_mplier >> MUL_BITS_PER_CYCLE;
        end else if (r_busy && (r_cnt != c_CNT_LAST)) begin
            r_cnt    <= r_cnt + c_CNT_ONE;
            r_acc    <= w_acc_next;
            r_mcand  <= w_mcand << MUL_BITS_PER_CYCLE;
            r_mplier <= w_mplier >> MUL_BITS_PER_CYCLE;
        end else if (o_done && i_take) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end
    end

    assign o_done    = r_busy && (r_cnt == c_CNT_LAST);
    assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Handshaked ALU with a registered result slot. Single-cycle ops
//               complete in one cycle; multiply is handed to alu_mul_iter and
//               the block stops accepting until the product is written out.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import pck_control::*;
#(
    parameter int WIDTH              = 32,
    parameter int MUL_BITS_PER_CYCLE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0]       i_sel_op,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_res,
    output logic [3:0]       o_flags
);

    localparam int c_SHW = $clog2(WIDTH);
    localparam logic [c_SHW:0] c_WIDTH_EXT = (c_SHW + 1)'(WIDTH);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_MUL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    alu_flags_t       r_flags;

    sel_alu_op_ext_e  w_op;
    logic             w_out_free;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_start;
    logic             w_mul_done;
    logic             w_take;
    logic [WIDTH-1:0] w_mul_product;
    alu_flags_t       w_mul_flags;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [c_SHW-1:0] w_shamt;
    logic [c_SHW:0]   w_rinv;
    logic [WIDTH-1:0] w_res;
    alu_flags_t       w_flags;

    assign w_op        = sel_alu_op_ext_e'(i_sel_op);
    assign w_is_mul    = (w_op == alux_mul);
    assign w_out_free  = !r_valid || i_ready;
    assign o_ready     = (r_state == c_S_IDLE) && w_out_free && !i_rst;
    assign w_accept    = i_valid && o_ready;
    assign w_mul_start = w_accept && w_is_mul;
    assign w_take      = (r_state == c_S_MUL) && w_mul_done && w_out_free;

    alu_mul_iter #(
        .WIDTH              (WIDTH),
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .i_clk     (i_clk),
        .i_start   (w_mul_start),
        .i_a       (i_op_a),
        .i_b       (i_op_b),
        .i_abort   (i_rst),
        .i_take    (w_take),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // Shared arithmetic terms for the single-cycle decode.
    always_comb begin
        w_sum     = {1'b0, i_op_a} + {1'b0, i_op_b};
        w_diff    = {1'b0, i_op_a} - {1'b0, i_op_b};
        w_add_ovf = (i_op_a[WIDTH-1] == i_op_b[WIDTH-1]) && (w_sum[WIDTH-1]  != i_op_a[WIDTH-1]);
        w_sub_ovf = (i_op_a[WIDTH-1] != i_op_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_op_a[WIDTH-1]);
        w_lt_s    = $signed(i_op_a) < $signed(i_op_b);
        w_lt_u    = i_op_a < i_op_b;
        w_shamt   = i_op_b[c_SHW-1:0];
        w_rinv    = c_WIDTH_EXT - {1'b0, w_shamt};
    end

    // Single-cycle op decode; anything outside the op set flags illegal.
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (w_op)
            alux_nop:  w_res = '0;
            alux_add:  begin
                w_res            = w_sum[WIDTH-1:0];
                w_flags.carry    = w_sum[WIDTH];
                w_flags.overflow = w_add_ovf;
            end
            alux_sub:  begin
                w_res            = w_diff[WIDTH-1:0];
                w_flags.carry    = w_diff[WIDTH];
                w_flags.overflow = w_sub_ovf;
            end
            alux_and:  w_res = i_op_a & i_op_b;
            alux_or:   w_res = i_op_a | i_op_b;
            alux_xor:  w_res = i_op_a ^ i_op_b;
            alux_slt:  w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
            alux_sltu: w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
            alux_sll:  w_res = i_op_a << w_shamt;
            alux_srl:  w_res = i_op_a >> w_shamt;
            alux_sra:  w_res = $unsigned($signed(i_op_a) >>> w_shamt);
            alux_cpa:  w_res = i_op_a;
            alux_cpb:  w_res = i_op_b;
            alux_min:  w_res = ($signed(i_op_b) < $signed(i_op_a)) ? i_op_b : i_op_a;
            alux_max:  w_res = ($signed(i_op_b) > $signed(i_op_a)) ? i_op_b : i_op_a;
            alux_minu: w_res = (i_op_b < i_op_a) ? i_op_b : i_op_a;
            alux_maxu: w_res = (i_op_b > i_op_a) ? i_op_b : i_op_a;
            // A shift by w_rinv == WIDTH yields zero, so amount 0 returns A.
            alux_rol:  w_res = (i_op_a << w_shamt) | (i_op_a >> w_rinv);
            alux_ror:  w_res = (i_op_a >> w_shamt) | (i_op_a << w_rinv);
            alux_mul:  w_res = '0;
            default:   w_flags.illegal = 1'b1;
        endcase
        w_flags.zero = (w_res == '0);
    end

    // Flags attached to a finished product: only zero can be set.
    always_comb begin
        w_mul_flags      = '0;
        w_mul_flags.zero = (w_mul_product == '0);
    end

    // Next-state: leave IDLE on a multiply, return once the product is written.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_mul_start) w_state_nxt = c_S_MUL;
            c_S_MUL:  if (w_take)      w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= c_S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Output slot: loads a new result, holds under back-pressure, else drains.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_flags <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
            r_flags <= w_flags;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_res   <= w_mul_product;
            r_flags <= w_mul_flags;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_res   = r_res;
    assign o_flags = r_flags;

endmodule
`default_nettype wire
